// File: rtl/head_edit_ctrl.sv
// head_edit_ctrl
// Per-packet sequencer for the header-edit datapath (Encap_Head / Decap_Head).
// Edit commands are queued in a small FIFO. Before each packet one command is
// loaded into registered configuration outputs, which then stay stable for
// every beat of that packet. Upstream beats are only accepted while a command
// is committed (ARMED/ACTIVE). Framing violations raise a sticky error flag.

module head_edit_ctrl #(
    parameter int CMD_DEPTH = 4,    // command FIFO depth, power of 2, >= 2
    parameter int HOFF_W    = 6,    // metaDataOffset width
    parameter int LEN_W     = 7,    // encap/decap length width
    parameter int ENC_W     = 128   // encap field width
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    // command push interface
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic [3:0]        i_cmd_sliceOff,
    input  logic [HOFF_W-1:0] i_cmd_dataOff,
    input  logic [ENC_W-1:0]  i_cmd_field,

    // packet beat handshake
    input  logic              i_pkt_valid,
    input  logic              i_pkt_start,
    input  logic              i_pkt_tail,
    output logic              o_pkt_ready,

    // configuration to the datapath
    output logic              o_encapEn,
    output logic              o_decapEn,
    output logic [LEN_W-1:0]  o_encapLength,
    output logic [LEN_W-1:0]  o_decapLength,
    output logic [3:0]        o_metaSliceOffset,
    output logic [HOFF_W-1:0] o_metaDataOffset,
    output logic [ENC_W-1:0]  o_encapField,

    // status
    output logic              o_busy,
    output logic              o_err,
    output logic [15:0]       o_pkt_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ARMED  = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam logic [1:0] OP_ENCAP = 2'b01;
    localparam logic [1:0] OP_DECAP = 2'b10;

    // ------------------------------------------------------------------
    // Command FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [1:0]        fifo_op    [CMD_DEPTH];
    logic [LEN_W-1:0]  fifo_len   [CMD_DEPTH];
    logic [3:0]        fifo_slice [CMD_DEPTH];
    logic [HOFF_W-1:0] fifo_doff  [CMD_DEPTH];
    logic [ENC_W-1:0]  fifo_field [CMD_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              cmd_ready_en;
    logic              push;
    logic              pop;

    // FSM and handshake
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              accept;
    logic [1:0]        cnt_inc;
    logic              err_set;

    // FIFO head, decoded for the LOAD cycle
    logic [1:0]        head_op;
    logic [LEN_W-1:0]  head_len;
    logic [3:0]        head_slice;
    logic [HOFF_W-1:0] head_doff;
    logic [ENC_W-1:0]  head_field;
    logic              head_is_encap;
    logic              head_is_decap;

    // ------------------------------------------------------------------
    // Handshake signals
    // ------------------------------------------------------------------
    // Ready follows the current occupancy only: a pop in the same cycle does
    // not open a slot until the next cycle. cmd_ready_en keeps it low while
    // in reset and for the edge that leaves reset.
    assign o_cmd_ready = cmd_ready_en && (count != FULL_CNT);
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state == ST_LOAD);

    assign o_pkt_ready = (state == ST_ARMED) || (state == ST_ACTIVE);
    assign accept      = i_pkt_valid && o_pkt_ready;
    assign o_busy      = (state != ST_IDLE);

    assign head_op       = fifo_op[rd_ptr];
    assign head_len      = fifo_len[rd_ptr];
    assign head_slice    = fifo_slice[rd_ptr];
    assign head_doff     = fifo_doff[rd_ptr];
    assign head_field    = fifo_field[rd_ptr];
    assign head_is_encap = (head_op == OP_ENCAP);
    assign head_is_decap = (head_op == OP_DECAP);

    // Write pushed commands into storage.
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, which are reset, so stale contents are never read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_op[wr_ptr]    <= i_cmd_op;
            fifo_len[wr_ptr]   <= i_cmd_len;
            fifo_slice[wr_ptr] <= i_cmd_sliceOff;
            fifo_doff[wr_ptr]  <= i_cmd_dataOff;
            fifo_field[wr_ptr] <= i_cmd_field;
        end
    end

    // FIFO pointers and occupancy; reset flushes every queued command.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the same pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cmd_ready_en <= 1'b0;
        end else begin
            cmd_ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state, packet-completion and framing-error decode.
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_inc    = 2'd0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (accept) begin
                    if (!i_pkt_start) begin
                        // Beat without a start: flag it, keep the command.
                        err_set = 1'b1;
                    end else if (i_pkt_tail) begin
                        cnt_inc    = 2'd1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (i_pkt_start) begin
                        // A start mid-packet closes the interrupted packet
                        // and opens a new one under the same config.
                        err_set = 1'b1;
                        cnt_inc = 2'd1;
                    end
                    if (i_pkt_tail) begin
                        cnt_inc    = cnt_inc + 2'd1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, sticky error flag and packet counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_err     <= 1'b0;
            o_pkt_cnt <= 16'd0;
        end else begin
            state     <= state_next;
            if (err_set) begin
                o_err <= 1'b1;
            end
            o_pkt_cnt <= o_pkt_cnt + 16'(cnt_inc);
        end
    end

    // Configuration registers: loaded only in LOAD, held through IDLE so the
    // datapath can drain under the previous packet's configuration.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_encapEn         <= 1'b0;
            o_decapEn         <= 1'b0;
            o_encapLength     <= '0;
            o_decapLength     <= '0;
            o_metaSliceOffset <= '0;
            o_metaDataOffset  <= '0;
            o_encapField      <= '0;
        end else if (state == ST_LOAD) begin
            o_encapEn         <= head_is_encap;
            o_decapEn         <= head_is_decap;
            o_encapLength     <= head_is_encap ? head_len : '0;
            o_decapLength     <= head_is_decap ? head_len : '0;
            o_metaSliceOffset <= head_slice;
            o_metaDataOffset  <= head_doff;
            o_encapField      <= head_is_encap ? head_field : '0;
        end
    end

endmodule

// File: tb/tb_head_edit_ctrl.sv
// Directed testbench for head_edit_ctrl.

module tb_head_edit_ctrl;

    localparam int CMD_DEPTH = 4;
    localparam int HOFF_W    = 6;
    localparam int LEN_W     = 7;
    localparam int ENC_W     = 128;
    localparam int CFG_W     = 2 + 2 * LEN_W + 4 + HOFF_W + ENC_W;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd_op;
    logic [LEN_W-1:0]  i_cmd_len;
    logic [3:0]        i_cmd_sliceOff;
    logic [HOFF_W-1:0] i_cmd_dataOff;
    logic [ENC_W-1:0]  i_cmd_field;
    logic              i_pkt_valid;
    logic              i_pkt_start;
    logic              i_pkt_tail;
    logic              o_pkt_ready;
    logic              o_encapEn;
    logic              o_decapEn;
    logic [LEN_W-1:0]  o_encapLength;
    logic [LEN_W-1:0]  o_decapLength;
    logic [3:0]        o_metaSliceOffset;
    logic [HOFF_W-1:0] o_metaDataOffset;
    logic [ENC_W-1:0]  o_encapField;
    logic              o_busy;
    logic              o_err;
    logic [15:0]       o_pkt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    head_edit_ctrl #(
        .CMD_DEPTH (CMD_DEPTH),
        .HOFF_W    (HOFF_W),
        .LEN_W     (LEN_W),
        .ENC_W     (ENC_W)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_cmd_valid       (i_cmd_valid),
        .o_cmd_ready       (o_cmd_ready),
        .i_cmd_op          (i_cmd_op),
        .i_cmd_len         (i_cmd_len),
        .i_cmd_sliceOff    (i_cmd_sliceOff),
        .i_cmd_dataOff     (i_cmd_dataOff),
        .i_cmd_field       (i_cmd_field),
        .i_pkt_valid       (i_pkt_valid),
        .i_pkt_start       (i_pkt_start),
        .i_pkt_tail        (i_pkt_tail),
        .o_pkt_ready       (o_pkt_ready),
        .o_encapEn         (o_encapEn),
        .o_decapEn         (o_decapEn),
        .o_encapLength     (o_encapLength),
        .o_decapLength     (o_decapLength),
        .o_metaSliceOffset (o_metaSliceOffset),
        .o_metaDataOffset  (o_metaDataOffset),
        .o_encapField      (o_encapField),
        .o_busy            (o_busy),
        .o_err             (o_err),
        .o_pkt_cnt         (o_pkt_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                            input logic [3:0] sl, input logic [HOFF_W-1:0] doff,
                            input logic [ENC_W-1:0] fld);
        i_cmd_valid    = 1'b1;
        i_cmd_op       = op;
        i_cmd_len      = len;
        i_cmd_sliceOff = sl;
        i_cmd_dataOff  = doff;
        i_cmd_field    = fld;
        tick();
        i_cmd_valid    = 1'b0;
    endtask

    task automatic beat(input logic s, input logic t);
        i_pkt_valid = 1'b1;
        i_pkt_start = s;
        i_pkt_tail  = t;
        tick();
        i_pkt_valid = 1'b0;
        i_pkt_start = 1'b0;
        i_pkt_tail  = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (o_pkt_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Expected configuration for a command, from the op decoding rules.
    function automatic logic [CFG_W-1:0] model_cfg(input logic [1:0] op,
                                                   input logic [LEN_W-1:0] len,
                                                   input logic [3:0] sl,
                                                   input logic [HOFF_W-1:0] doff,
                                                   input logic [ENC_W-1:0] fld);
        logic en;
        logic de;
        en = (op == 2'b01);
        de = (op == 2'b10);
        return {en, de,
                en ? len : {LEN_W{1'b0}},
                de ? len : {LEN_W{1'b0}},
                sl, doff,
                en ? fld : {ENC_W{1'b0}}};
    endfunction

    function automatic logic [CFG_W-1:0] cfg_now();
        return {o_encapEn, o_decapEn, o_encapLength, o_decapLength,
                o_metaSliceOffset, o_metaDataOffset, o_encapField};
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [CFG_W+19:0] all_out;
        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = '0;
        i_cmd_len   = '0;
        i_cmd_sliceOff = '0;
        i_cmd_dataOff  = '0;
        i_cmd_field    = '0;
        i_pkt_valid = 1'b0;
        i_pkt_start = 1'b0;
        i_pkt_tail  = 1'b0;
        tick();
        tick();
        all_out = {o_cmd_ready, o_pkt_ready, cfg_now(), o_busy, o_err, o_pkt_cnt};
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        i_rst_n = 1'b1;
        n_cmp++;
        if (o_cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_ready_early: got %b want 0", o_cmd_ready);
        end
        tick();
        n_cmp++;
        if (o_cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", o_cmd_ready);
        end
    endtask

    task automatic test_encap_two_beat();
        logic [CFG_W-1:0] exp_cfg;
        logic [ENC_W-1:0] fld;
        fld = 128'hffff_eeee_dddd_cccc_bbbb_aaaa_9999_8888;
        exp_cfg = model_cfg(2'b01, 7'd7, 4'd0, 6'd0, fld);
        push_cmd(2'b01, 7'd7, 4'd0, 6'd0, fld);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_idle_after_push: busy %b want 0", o_busy);
        end
        tick(); // LOAD
        n_cmp++;
        if ({o_busy, o_pkt_ready, o_encapEn} !== 3'b100) begin
            n_bad++;
            $display("FAIL t1_load: busy/ready/encapEn %b want 100",
                     {o_busy, o_pkt_ready, o_encapEn});
        end
        tick(); // ARMED, config valid
        n_cmp++;
        if (cfg_now() !== exp_cfg) begin
            n_bad++;
            $display("FAIL t1_cfg: got %h want %h", cfg_now(), exp_cfg);
        end
        n_cmp++;
        if (o_pkt_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_armed_ready: got %b want 1", o_pkt_ready);
        end
        beat(1'b1, 1'b0);
        n_cmp++;
        if ({o_busy, o_pkt_ready, o_pkt_cnt} !== {2'b11, 16'd0}) begin
            n_bad++;
            $display("FAIL t1_active: busy/ready/cnt %b/%b/%0d want 1/1/0",
                     o_busy, o_pkt_ready, o_pkt_cnt);
        end
        beat(1'b0, 1'b1);
        n_cmp++;
        if ({o_busy, o_pkt_ready, o_pkt_cnt} !== {2'b00, 16'd1}) begin
            n_bad++;
            $display("FAIL t1_after_tail: busy/ready/cnt %b/%b/%0d want 0/0/1",
                     o_busy, o_pkt_ready, o_pkt_cnt);
        end
        n_cmp++;
        if (cfg_now() !== exp_cfg) begin
            n_bad++;
            $display("FAIL t1_cfg_held: got %h want %h", cfg_now(), exp_cfg);
        end
    endtask

    task automatic test_decap_single();
        logic [CFG_W-1:0] exp_cfg;
        exp_cfg = model_cfg(2'b10, 7'd12, 4'd1, 6'd1, 128'h5555);
        push_cmd(2'b10, 7'd12, 4'd1, 6'd1, 128'h5555);
        tick(); // LOAD
        tick(); // ARMED
        n_cmp++;
        if (cfg_now() !== exp_cfg) begin
            n_bad++;
            $display("FAIL t2_cfg: got %h want %h", cfg_now(), exp_cfg);
        end
        beat(1'b1, 1'b1);
        n_cmp++;
        if ({o_busy, o_pkt_cnt} !== {1'b0, 16'd2}) begin
            n_bad++;
            $display("FAIL t2_single: busy/cnt %b/%0d want 0/2", o_busy, o_pkt_cnt);
        end
        tick();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t2_stays_idle: busy %b want 0", o_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]        t_op   [5];
        logic [LEN_W-1:0]  t_len  [5];
        logic [3:0]        t_sl   [5];
        logic [HOFF_W-1:0] t_doff [5];
        logic [ENC_W-1:0]  t_fld  [5];
        logic [CFG_W-1:0]  exp_cfg;
        bit ok;
        t_op   = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
        t_len  = '{7'd3, 7'd20, 7'd9, 7'd127, 7'd5};
        t_sl   = '{4'd2, 4'd3, 4'd4, 4'd15, 4'd1};
        t_doff = '{6'd5, 6'd9, 6'd10, 6'd63, 6'd2};
        t_fld  = '{128'h0123_4567_89ab_cdef_0011_2233_4455_6677,
                   128'hdead_beef_dead_beef_dead_beef_dead_beef,
                   128'h1111_2222_3333_4444_5555_6666_7777_8888,
                   {ENC_W{1'b1}},
                   128'hcafe_f00d};
        // First command goes straight to ARMED, the next four fill the FIFO.
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (o_cmd_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL t3_ready_before_push%0d: got %b want 1", k, o_cmd_ready);
            end
            push_cmd(t_op[k], t_len[k], t_sl[k], t_doff[k], t_fld[k]);
        end
        n_cmp++;
        if (o_cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL t3_full: cmd_ready %b want 0", o_cmd_ready);
        end
        // Push attempt while full must be dropped.
        push_cmd(2'b01, 7'd1, 4'd7, 6'd7, 128'hbad);
        for (int k = 0; k < 5; k++) begin
            wait_ready(ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL t3_wait_ready%0d: pkt_ready never rose", k);
            end
            exp_cfg = model_cfg(t_op[k], t_len[k], t_sl[k], t_doff[k], t_fld[k]);
            n_cmp++;
            if (cfg_now() !== exp_cfg) begin
                n_bad++;
                $display("FAIL t3_cfg%0d: got %h want %h", k, cfg_now(), exp_cfg);
            end
            beat(1'b1, 1'b1);
            if (k == 0) begin
                n_cmp++;
                if (o_cmd_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL t3_ready_idle: got %b want 0", o_cmd_ready);
                end
                tick(); // LOAD: pop does not free a slot yet
                n_cmp++;
                if (o_cmd_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL t3_ready_load: got %b want 0", o_cmd_ready);
                end
                tick(); // one cycle after LOAD
                n_cmp++;
                if (o_cmd_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL t3_ready_after_load: got %b want 1", o_cmd_ready);
                end
            end
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if ({o_busy, o_pkt_cnt} !== {1'b0, 16'd7}) begin
            n_bad++;
            $display("FAIL t3_drained: busy/cnt %b/%0d want 0/7", o_busy, o_pkt_cnt);
        end
    endtask

    task automatic test_gate_empty();
        i_pkt_valid = 1'b1;
        i_pkt_start = 1'b1;
        i_pkt_tail  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (o_pkt_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL t4_gated%0d: pkt_ready %b want 0", i, o_pkt_ready);
            end
        end
        n_cmp++;
        if (o_pkt_cnt !== 16'd7) begin
            n_bad++;
            $display("FAIL t4_cnt: got %0d want 7", o_pkt_cnt);
        end
        push_cmd(2'b01, 7'd2, 4'd0, 6'd3, 128'h77);
        n_cmp++;
        if (o_pkt_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL t4_ready_push+0: got %b want 0", o_pkt_ready);
        end
        tick();
        n_cmp++;
        if (o_pkt_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL t4_ready_push+1: got %b want 0", o_pkt_ready);
        end
        tick();
        n_cmp++;
        if (o_pkt_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL t4_ready_push+2: got %b want 1", o_pkt_ready);
        end
        i_pkt_valid = 1'b0;
        i_pkt_start = 1'b0;
    endtask

    task automatic test_framing();
        logic [CFG_W-1:0] exp_cfg;
        exp_cfg = model_cfg(2'b01, 7'd2, 4'd0, 6'd3, 128'h77);
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_err_clear: got %b want 0", o_err);
        end
        beat(1'b0, 1'b0); // ARMED, no start
        n_cmp++;
        if ({o_err, o_busy, o_pkt_ready} !== 3'b111) begin
            n_bad++;
            $display("FAIL t5_nostart: err/busy/ready %b want 111",
                     {o_err, o_busy, o_pkt_ready});
        end
        n_cmp++;
        if ({cfg_now(), o_pkt_cnt} !== {exp_cfg, 16'd7}) begin
            n_bad++;
            $display("FAIL t5_cmd_held: cfg %h cnt %0d want %h / 7",
                     cfg_now(), o_pkt_cnt, exp_cfg);
        end
        beat(1'b1, 1'b0); // -> ACTIVE
        beat(1'b1, 1'b0); // second start while ACTIVE
        n_cmp++;
        if ({o_err, o_pkt_ready, o_pkt_cnt} !== {2'b11, 16'd8}) begin
            n_bad++;
            $display("FAIL t5_restart: err/ready/cnt %b/%b/%0d want 1/1/8",
                     o_err, o_pkt_ready, o_pkt_cnt);
        end
        beat(1'b0, 1'b1);
        n_cmp++;
        if ({o_err, o_busy, o_pkt_cnt} !== {2'b10, 16'd9}) begin
            n_bad++;
            $display("FAIL t5_tail: err/busy/cnt %b/%b/%0d want 1/0/9",
                     o_err, o_busy, o_pkt_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [CFG_W+19:0] all_out;
        logic [CFG_W-1:0]  exp_cfg;
        bit ok;
        push_cmd(2'b01, 7'd8, 4'd1, 6'd1, 128'haa);
        push_cmd(2'b10, 7'd9, 4'd2, 6'd2, 128'hbb);
        push_cmd(2'b00, 7'd1, 4'd3, 6'd3, 128'hcc);
        beat(1'b1, 1'b0);
        n_cmp++;
        if ({o_busy, o_pkt_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL t6_active: busy/ready %b want 11", {o_busy, o_pkt_ready});
        end
        i_rst_n = 1'b0;
        #1;
        all_out = {o_cmd_ready, o_pkt_ready, cfg_now(), o_busy, o_err, o_pkt_cnt};
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL t6_reset_outputs: got %h want 0", all_out);
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        i_pkt_valid = 1'b1;
        i_pkt_start = 1'b1;
        i_pkt_tail  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({o_pkt_ready, o_busy, o_cmd_ready} !== 3'b001) begin
                n_bad++;
                $display("FAIL t6_flushed%0d: ready/busy/cmd_ready %b want 001",
                         i, {o_pkt_ready, o_busy, o_cmd_ready});
            end
        end
        exp_cfg = model_cfg(2'b10, 7'd4, 4'd5, 6'd6, 128'hdd);
        push_cmd(2'b10, 7'd4, 4'd5, 6'd6, 128'hdd);
        wait_ready(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL t6_wait_ready: pkt_ready never rose");
        end
        n_cmp++;
        if (cfg_now() !== exp_cfg) begin
            n_bad++;
            $display("FAIL t6_cfg: got %h want %h", cfg_now(), exp_cfg);
        end
        tick(); // held single-beat packet accepted
        i_pkt_valid = 1'b0;
        i_pkt_start = 1'b0;
        i_pkt_tail  = 1'b0;
        n_cmp++;
        if ({o_busy, o_err, o_pkt_cnt} !== {2'b00, 16'd1}) begin
            n_bad++;
            $display("FAIL t6_after: busy/err/cnt %b/%b/%0d want 0/0/1",
                     o_busy, o_err, o_pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_encap_two_beat();
        test_decap_single();
        test_back_to_back();
        test_gate_empty();
        test_framing();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
